// File: rtl/inport_conditioner.sv
// Board input front end: syncs and debounces switches/buttons, holds a word.
// Ports: Clock, Reset(sync, low), sw_raw, load_btn_raw, stop_btn_raw, inport_read
//        -> inport_data, data_valid, overrun, stop_level, sw_stable.
module inport_conditioner #(
  parameter int SW_W       = 8,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 20,
  parameter int SIGN_EXT   = 0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            load_btn_raw,
  input  logic            stop_btn_raw,
  input  logic            inport_read,
  output logic [31:0]     inport_data,
  output logic            data_valid,
  output logic            overrun,
  output logic            stop_level,
  output logic [SW_W-1:0] sw_stable
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  swMeta;
  logic [SW_W-1:0]  swSync;
  logic [SW_W-1:0]  swPrev;
  logic [CNT_W-1:0] swCnt;

  logic             loadMeta;
  logic             loadSync;
  logic             loadStable;
  logic             loadStableD;
  logic [CNT_W-1:0] loadCnt;

  logic             stopMeta;
  logic             stopSync;
  logic             stopStable;
  logic [CNT_W-1:0] stopCnt;

  logic [0:0]       state;
  logic             loadRise;

  function automatic logic [31:0] extend(
    input logic [SW_W-1:0] v
  );
    logic [31:0] r;
    r = {32{(SIGN_EXT != 0) & v[SW_W-1]}};
    r[SW_W-1:0] = v;
    return r;
  endfunction

  assign loadRise   = loadStable & ~loadStableD;
  assign data_valid = (state == FULL);
  assign stop_level = stopStable;

  // two-flop synchronisers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      swMeta   <= '0;
      swSync   <= '0;
      loadMeta <= 1'b0;
      loadSync <= 1'b0;
      stopMeta <= 1'b0;
      stopSync <= 1'b0;
    end else begin
      swMeta   <= sw_raw;
      swSync   <= swMeta;
      loadMeta <= load_btn_raw;
      loadSync <= loadMeta;
      stopMeta <= stop_btn_raw;
      stopSync <= stopMeta;
    end
  end

  // buttons: accept a level after DEB_CYCLES
  // consecutive disagreeing samples
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      loadStable  <= 1'b0;
      loadStableD <= 1'b0;
      loadCnt     <= '0;
      stopStable  <= 1'b0;
      stopCnt     <= '0;
    end else begin
      loadStableD <= loadStable;
      if (loadSync != loadStable) begin
        if (loadCnt == DEB_LAST) begin
          loadStable <= loadSync;
          loadCnt    <= '0;
        end else begin
          loadCnt <= loadCnt + 1'b1;
        end
      end else begin
        loadCnt <= '0;
      end
      if (stopSync != stopStable) begin
        if (stopCnt == DEB_LAST) begin
          stopStable <= stopSync;
          stopCnt    <= '0;
        end else begin
          stopCnt <= stopCnt + 1'b1;
        end
      end else begin
        stopCnt <= '0;
      end
    end
  end

  // switches as a group; counter holds at
  // DEB_LAST so a settled vector keeps loading
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      swPrev    <= '0;
      swCnt     <= '0;
      sw_stable <= '0;
    end else begin
      swPrev <= swSync;
      if (swSync != swPrev) begin
        swCnt <= '0;
      end else if (swCnt == DEB_LAST) begin
        sw_stable <= swSync;
      end else begin
        swCnt <= swCnt + 1'b1;
      end
    end
  end

  // a read in the same cycle as a new load
  // consumed the old word, so no overrun
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= EMPTY;
      inport_data <= '0;
      overrun     <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (loadRise) begin
            state       <= FULL;
            inport_data <= extend(sw_stable);
          end
        end
        FULL: begin
          if (loadRise) begin
            inport_data <= extend(sw_stable);
            if (!inport_read) overrun <= 1'b1;
          end else if (inport_read) begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inport_conditioner.sv
// Testbench for inport_conditioner: zero- and sign-extending
// instances against a window-based reference model.
module tb_inport_conditioner;

  localparam int DEB = 16;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  swRaw = '0;
  logic        loadRaw = 1'b0;
  logic        stopRaw = 1'b0;
  logic        rd = 1'b0;

  logic [31:0] data0, data1;
  logic        dv0, dv1, ov0, ov1;
  logic        stop0, stop1;
  logic [7:0]  sws0, sws1;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  inport_conditioner #(
    .SW_W(8), .DEB_CYCLES(DEB),
    .CNT_W(20), .SIGN_EXT(0)
  ) u0 (
    .Clock(Clock), .Reset(Reset),
    .sw_raw(swRaw),
    .load_btn_raw(loadRaw),
    .stop_btn_raw(stopRaw),
    .inport_read(rd),
    .inport_data(data0),
    .data_valid(dv0),
    .overrun(ov0),
    .stop_level(stop0),
    .sw_stable(sws0)
  );

  inport_conditioner #(
    .SW_W(8), .DEB_CYCLES(DEB),
    .CNT_W(20), .SIGN_EXT(1)
  ) u1 (
    .Clock(Clock), .Reset(Reset),
    .sw_raw(swRaw),
    .load_btn_raw(loadRaw),
    .stop_btn_raw(stopRaw),
    .inport_read(rd),
    .inport_data(data1),
    .data_valid(dv1),
    .overrun(ov1),
    .stop_level(stop1),
    .sw_stable(sws1)
  );

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        dv;
    logic        ov;
    logic        st;
    logic [7:0]  sw;
  } exp_t;

  exp_t expQ[$];

  // history of raw samples, newest last; -1 marks
  // a reset boundary no settling window may span
  int ldH[$], stH[$], swH[$];
  bit mLs, mLsPrev, mSs, mFull, mOvr;
  logic [7:0]  mSw;
  logic [31:0] mD0, mD1;

  // a button level changes once the DEB samples
  // that reached the comparison all disagree with it
  function automatic bit btnFlip(
    input int h[$], input bit cur
  );
    int n;
    n = h.size();
    if (n < DEB + 2) return 1'b0;
    for (int k = 2; k <= DEB + 1; k++) begin
      if (h[n-1-k] < 0) return 1'b0;
      if (h[n-1-k] == int'(cur)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // switches settle after DEB+1 identical samples
  function automatic int swSettled(input int h[$]);
    int n;
    int v;
    n = h.size();
    if (n < DEB + 3) return -1;
    v = h[n-3];
    for (int k = 2; k <= DEB + 2; k++) begin
      if (h[n-1-k] != v) return -1;
    end
    return v;
  endfunction

  task automatic trim();
    while (ldH.size() > DEB + 4) void'(ldH.pop_front());
    while (stH.size() > DEB + 4) void'(stH.pop_front());
    while (swH.size() > DEB + 4) void'(swH.pop_front());
  endtask

  initial begin
    bit rise, nl, ns;
    int sv;
    exp_t e;
    forever begin
      @(posedge Clock);
      if (!Reset) begin
        mLs = 0; mLsPrev = 0; mSs = 0;
        mFull = 0; mOvr = 0;
        mSw = '0; mD0 = '0; mD1 = '0;
        ldH = '{-1, 0, 0, 0};
        stH = '{-1, 0, 0, 0};
        swH = '{-1, 0, 0, 0};
      end else begin
        rise = mLs && !mLsPrev;
        if (rise) begin
          if (mFull && !rd) mOvr = 1;
          mFull = 1;
          mD0 = {24'h0, mSw};
          mD1 = {{24{mSw[7]}}, mSw};
        end else if (rd) begin
          mFull = 0;
        end
        ldH.push_back(int'(loadRaw));
        stH.push_back(int'(stopRaw));
        swH.push_back(int'(swRaw));
        trim();
        nl = btnFlip(ldH, mLs) ? !mLs : mLs;
        ns = btnFlip(stH, mSs) ? !mSs : mSs;
        sv = swSettled(swH);
        if (sv >= 0) mSw = sv[7:0];
        mLsPrev = mLs;
        mLs = nl;
        mSs = ns;
      end
      e.d0 = mD0; e.d1 = mD1;
      e.dv = mFull; e.ov = mOvr;
      e.st = mSs; e.sw = mSw;
      expQ.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("data0", data0, e.d0);
        chk("data1", data1, e.d1);
        chk("valid", {31'h0, dv0}, {31'h0, e.dv});
        chk("valid1", {31'h0, dv1}, {31'h0, e.dv});
        chk("overrun", {31'h0, ov0}, {31'h0, e.ov});
        chk("overrun1", {31'h0, ov1}, {31'h0, e.ov});
        chk("stop", {31'h0, stop0}, {31'h0, e.st});
        chk("swStable", {24'h0, sws0}, {24'h0, e.sw});
        chk("swStable1", {24'h0, sws1}, {24'h0, e.sw});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic press(input int len);
    @(negedge Clock);
    loadRaw = 1'b1;
    idle(len);
    loadRaw = 1'b0;
    idle(25);
  endtask

  task automatic readPulse();
    @(negedge Clock);
    rd = 1'b1;
    @(negedge Clock);
    rd = 1'b0;
  endtask

  task automatic setSw(input logic [7:0] v);
    @(negedge Clock);
    swRaw = v;
    idle(25);
  endtask

  initial begin
    int segs;
    int len;
    // reset with inputs toggling
    repeat (3) begin
      @(negedge Clock);
      swRaw = 8'($urandom);
      loadRaw = 1'($urandom);
      stopRaw = 1'($urandom);
      rd = 1'($urandom);
    end
    @(negedge Clock);
    Reset = 1'b1;
    swRaw = '0; loadRaw = 0;
    stopRaw = 0; rd = 0;
    idle(30);

    // single long press, latency check
    setSw(8'hA5);
    @(negedge Clock);
    loadRaw = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clock);
      if (j == 18) chk("dvBefore19", {31'h0, dv0}, 32'h0);
      if (j == 19) begin
        chk("dvAt19", {31'h0, dv0}, 32'h1);
        chk("dataA5", data0, 32'h0000_00A5);
      end
    end
    loadRaw = 1'b0;
    idle(25);
    chk("oneCapture", {31'h0, ov0}, 32'h0);
    readPulse();

    // sign extension
    setSw(8'h85);
    press(30);
    chk("zext85", data0, 32'h0000_0085);
    chk("sext85", data1, 32'hFFFF_FF85);
    readPulse();

    // short pulses never capture
    repeat (5) begin
      @(negedge Clock);
      loadRaw = 1'b1;
      idle(10);
      loadRaw = 1'b0;
      idle(9);
    end
    idle(25);
    chk("glitchNoCap", {31'h0, dv0}, 32'h0);

    // overwrite without read
    setSw(8'h11);
    press(30);
    setSw(8'h22);
    press(30);
    chk("data22", data0, 32'h22);
    chk("ovSet", {31'h0, ov0}, 32'h1);
    readPulse();
    idle(2);
    chk("dvCleared", {31'h0, dv0}, 32'h0);
    chk("ovSticky", {31'h0, ov0}, 32'h1);

    // reset, then read coincident with load rise
    @(negedge Clock);
    Reset = 1'b0;
    idle(2);
    Reset = 1'b1;
    setSw(8'h33);
    press(30);
    setSw(8'h44);
    @(negedge Clock);
    loadRaw = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge Clock);
      if (j == 18) rd = 1'b1;
      if (j == 19) begin
        rd = 1'b0;
        chk("coinData", data0, 32'h44);
        chk("coinValid", {31'h0, dv0}, 32'h1);
        chk("coinNoOv", {31'h0, ov0}, 32'h0);
      end
    end
    loadRaw = 1'b0;
    idle(25);

    // STOP level
    @(negedge Clock);
    stopRaw = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge Clock);
      if (j == 17) chk("stopPre", {31'h0, stop0}, 32'h0);
      if (j == 18) chk("stopOn", {31'h0, stop0}, 32'h1);
    end
    stopRaw = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge Clock);
      if (j == 17) chk("stopHold", {31'h0, stop0}, 32'h1);
      if (j == 18) chk("stopOff", {31'h0, stop0}, 32'h0);
    end

    // randomized segments
    segs = 0;
    while (segs < 150) begin
      segs++;
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 59) == 0) begin
        Reset = 1'b0;
        idle($urandom_range(1, 3));
        Reset = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) swRaw = 8'($urandom);
      loadRaw = 1'($urandom);
      stopRaw = 1'($urandom);
      for (int j = 0; j < len; j++) begin
        rd = ($urandom_range(0, 7) == 0);
        @(negedge Clock);
      end
    end
    rd = 1'b0;
    loadRaw = 1'b0;
    stopRaw = 1'b0;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
